round_judge: RTL and testbench

- End-of-round resolver for the 21 card game.
- Player score registers are written as cards are drawn; this block is their reader.
- On a start pulse it reads each player's score in turn through a synchronous-read select port and compares it against the dealer score.
- It produces per-player win/push/lose outcomes, a win count, and a done pulse for the turn controller and the HEX display logic.

---
 rtl/round_judge.sv | 94 +++++++++
 tb/tb_round_judge.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/round_judge.sv
// End-of-round resolver for the 21 card game: walks the player score bank through a
// registered-read select port and grades each player against the captured dealer total.
module round_judge #(
  parameter int NUM_PLAYERS = 4,
  parameter int SCORE_W     = 6,
  parameter int TARGET      = 21
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SCORE_W-1:0]       dealer_score,
  output logic [1:0]               rd_player,
  input  logic [SCORE_W-1:0]       score_in,
  output logic                     busy,
  output logic                     done,
  output logic [2*NUM_PLAYERS-1:0] result,
  output logic [2:0]               win_count,
  output logic                     result_valid
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [1:0] LOSE = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] WIN  = 2'b10;

  localparam logic [1:0]         LAST     = 2'(NUM_PLAYERS - 1);
  localparam logic [SCORE_W-1:0] TARGET_S = SCORE_W'(TARGET);

  logic [1:0]         state;
  logic [1:0]         idx;
  logic [1:0]         verdict;
  logic [SCORE_W-1:0] dealer;

  // A player bust loses outright, so it is tested before the dealer bust.
  always_comb begin
    // NOTE: default assignment first so no path leaves verdict unassigned (no latch).
    verdict = LOSE;
    if (score_in > TARGET_S)    verdict = LOSE;
    else if (dealer > TARGET_S) verdict = WIN;
    else if (score_in > dealer) verdict = WIN;
    else if (score_in == dealer) verdict = PUSH;
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      rd_player    <= '0;
      dealer       <= '0;
      result       <= '0;
      win_count    <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_ISSUE;
            idx          <= '0;
            rd_player    <= '0;
            dealer       <= dealer_score;
            result       <= '0;
            win_count    <= '0;
            result_valid <= 1'b0;
          end
        end
        S_ISSUE: state <= S_CAPTURE;
        S_CAPTURE: begin
          // score_in is the bank's answer to the select issued in the previous cycle.
          result[2*idx +: 2] <= verdict;
          if (verdict == WIN) win_count <= win_count + 3'd1;
          if (idx == LAST) begin
            state        <= S_DONE;
            result_valid <= 1'b1;
          end else begin
            idx       <= idx + 2'd1;
            rd_player <= idx + 2'd1;
            state     <= S_ISSUE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_judge.sv
// Self-checking bench for round_judge: registered-read score bank model plus a
// rule-level reference that grades each round from the dealer and player totals.
module tb_round_judge;

  localparam int NP = 4;
  localparam int SW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [SW-1:0] dealer_score;
  logic [1:0]    rd_player;
  logic [SW-1:0] score_in;
  logic          busy;
  logic          done;
  logic [7:0]    result;
  logic [2:0]    win_count;
  logic          result_valid;

  logic [SW-1:0] bank [NP];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  // Score register bank: answer appears one cycle after the select.
  always @(posedge clock) score_in <= bank[rd_player];

  round_judge #(.NUM_PLAYERS(NP), .SCORE_W(SW), .TARGET(21)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .dealer_score (dealer_score),
    .rd_player    (rd_player),
    .score_in     (score_in),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .win_count    (win_count),
    .result_valid (result_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Game rules straight from the table: player bust, dealer bust, compare.
  function automatic logic [1:0] ref_outcome(input int p, input int d);
    if (p > 21) return 2'b00;
    if (d > 21) return 2'b10;
    if (p > d)  return 2'b10;
    if (p == d) return 2'b01;
    return 2'b00;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Caller is in cycle 0 on entry; returns in cycle 10 (DUT idle again).
  task automatic run_round(input int d, input int s[NP], input bit hold,
                           input int extra_start, input int swap_cyc, input int swap_val);
    logic [7:0] exp_res;
    int         exp_wins;
    exp_res  = '0;
    exp_wins = 0;
    for (int i = 0; i < NP; i++) begin
      bank[i] = SW'(s[i]);
      exp_res[2*i +: 2] = ref_outcome(s[i], d);
      if (ref_outcome(s[i], d) == 2'b10) exp_wins++;
    end
    dealer_score = SW'(d);
    start        = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = hold || (c == extra_start);
      if (c == swap_cyc) dealer_score = SW'(swap_val);
      check("busy", 32'(busy), 32'(c <= 9));
      check("done", 32'(done), 32'(c == 9));
      check("result_valid", 32'(result_valid), 32'(c >= 9));
      if (c == 1) begin
        check("result_cleared", 32'(result), 32'd0);
        check("win_count_cleared", 32'(win_count), 32'd0);
      end
      if ((c % 2 == 1) && (c <= 7)) check("rd_player", 32'(rd_player), 32'((c - 1) / 2));
      if (c >= 9) begin
        check("result", 32'(result), 32'(exp_res));
        check("win_count", 32'(win_count), 32'(exp_wins));
      end
    end
  endtask

  initial begin
    int s[NP];
    int d;

    reset        = 1'b1;
    start        = 1'b0;
    dealer_score = '0;
    for (int i = 0; i < NP; i++) bank[i] = '0;
    tick();
    tick();
    check("rst_rd_player", 32'(rd_player), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_win_count", 32'(win_count), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    reset = 1'b0;
    tick();

    // Directed rounds: basic, dealer bust, start while busy, start in DONE.
    run_round(18, '{20, 18, 17, 22}, 1'b0, -1, -1, 0);
    run_round(25, '{22, 5, 21, 0},   1'b0, -1, -1, 0);
    run_round(18, '{20, 18, 17, 22}, 1'b0, 4,  -1, 0);
    run_round(21, '{21, 22, 0, 20},  1'b0, 9,  -1, 0);
    // Dealer changes mid-scan, then an immediate restart.
    run_round(17, '{19, 19, 19, 19}, 1'b0, -1, 3, 30);
    run_round(19, '{19, 19, 19, 19}, 1'b0, -1, -1, 0);
    // Start held high: a new round every 10 cycles.
    run_round(0,  '{0, 1, 34, 21},   1'b1, -1, -1, 0);
    run_round(10, '{11, 9, 10, 33},  1'b1, -1, -1, 0);
    run_round(22, '{22, 21, 23, 3},  1'b0, -1, -1, 0);

    // Reset in the middle of a scan.
    bank[0] = 6'd20; bank[1] = 6'd10; bank[2] = 6'd5; bank[3] = 6'd1;
    dealer_score = 6'd9;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
      if (c == 5) reset = 1'b1;
    end
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_result_valid", 32'(result_valid), 32'd0);
    check("abort_win_count", 32'(win_count), 32'd0);
    check("abort_rd_player", 32'(rd_player), 32'd0);
    for (int c = 0; c < 6; c++) begin
      check("abort_no_done", 32'(done), 32'd0);
      tick();
    end

    // Reset and start together: reset wins.
    reset = 1'b1;
    start = 1'b1;
    tick();
    check("rst_start_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("rst_start_idle", 32'(busy), 32'd0);

    // Randomized rounds, biased toward ties and the 21 boundary.
    for (int r = 0; r < 40; r++) begin
      d = int'($urandom_range(0, 34));
      for (int i = 0; i < NP; i++) begin
        case ($urandom_range(0, 3))
          0:       s[i] = d;
          1:       s[i] = 21;
          default: s[i] = int'($urandom_range(0, 34));
        endcase
      end
      run_round(d, s, 1'b0, -1, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
